// File: rtl/aes_v2_scalable_pkg.sv
// Shared constants, FSM encoding and configuration helpers for the scalable
// AES SubBytes / MixColumn instruction unit.
package aes_v2_scalable_pkg;

  // AES field polynomial x^8 + x^4 + x^3 + x + 1, with the x^8 term dropped.
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Coefficients applied to b[i], b[i+1], b[i+2], b[i+3] for each output byte.
  localparam logic [0:3][7:0] MIX_ENC_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] MIX_DEC_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int SBOX_COUNT_LEGAL [3] = '{1, 2, 4};

  function automatic bit sbox_count_is_legal(input int n);
    bit ok;
    ok = 1'b0;
    foreach (SBOX_COUNT_LEGAL[i])
      if (SBOX_COUNT_LEGAL[i] == n) ok = 1'b1;
    return ok;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_v2_scalable_sbox.sv
// Combinational AES S-box: forward or inverse byte substitution computed from
// the GF(2^8) multiplicative inverse and the AES affine transform.
module aes_sbox
  import aes_v2_scalable_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  localparam logic [7:0] AFFINE_FWD_C = 8'h63;
  localparam logic [7:0] AFFINE_INV_C = 8'h05;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the inverse for a != 0 and maps 0 to 0, as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ AFFINE_FWD_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ AFFINE_INV_C;
  endfunction

  always_comb begin
    out = inv ? gf_inv(affine_inv(in)) : affine_fwd(gf_inv(in));
  end

endmodule

// File: rtl/aes_v2_scalable.sv
// AES SubBytes / MixColumn instruction unit with a configurable number of
// S-box instances; SubBytes takes 4/SBOX_COUNT cycles, MixColumn takes one.
module aes_v2_scalable
  import aes_v2_scalable_pkg::*;
#(
  parameter int SBOX_COUNT  = 4,
  parameter int HOLD_RESULT = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        sub,
  input  logic        enc,
  input  logic        flush,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int         STEPS     = (SBOX_COUNT > 0) ? 4 / SBOX_COUNT : 1;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  if (!sbox_count_is_legal(SBOX_COUNT)) begin : g_bad_cfg
    $error("aes_v2_scalable: SBOX_COUNT must be 1, 2 or 4");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // SubBytes lane i sits in byte i of this word.
  function automatic logic [31:0] lane_word(input logic [31:0] a, input logic [31:0] b);
    return {b[31:24], a[23:16], b[15:8], a[7:0]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a, input logic [31:0] b,
                                             input logic e);
    logic [3:0][7:0] col;
    logic [0:3][7:0] coef;
    logic [31:0]     res;
    logic [7:0]      acc;
    col  = {b[31:24], b[23:16], a[15:8], a[7:0]};
    coef = e ? MIX_ENC_COEF : MIX_DEC_COEF;
    res  = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[k], col[(i + k) % 4]);
      res[8*i +: 8] = acc;
    end
    return res;
  endfunction

  function automatic logic [1:0] lane_of(input logic [1:0] step, input int j);
    return 2'(int'(step) * SBOX_COUNT + j);
  endfunction

  state_e      r_state;
  logic [1:0]  r_step;
  logic        r_enc;
  logic [31:0] r_lanes;
  logic [31:0] r_acc;
  logic        r_ready;
  logic [31:0] r_rd;

  logic        w_idle;
  logic [1:0]  w_step;
  logic        w_inv;
  logic [31:0] w_lane_src;
  logic [31:0] w_sub_next;
  logic [31:0] w_mix;
  logic [7:0]  w_sbox_in  [SBOX_COUNT];
  logic [7:0]  w_sbox_out [SBOX_COUNT];
  logic        w_unused_ops;

  // Step 0 runs in the acceptance cycle from live inputs; later steps read the
  // captured lanes, so the requester may change its inputs once accepted.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_step     = w_idle ? 2'd0 : r_step;
  assign w_inv      = w_idle ? ~enc : ~r_enc;
  assign w_lane_src = w_idle ? lane_word(rs1, rs2) : r_lanes;
  assign w_mix      = mix_column(rs1, rs2, enc);

  assign w_unused_ops = ^{rs1[31:24], rs2[7:0]};

  always_comb begin
    for (int j = 0; j < SBOX_COUNT; j++)
      w_sbox_in[j] = w_lane_src[8*lane_of(w_step, j) +: 8];
  end

  always_comb begin
    w_sub_next = r_acc;
    for (int j = 0; j < SBOX_COUNT; j++)
      w_sub_next[8*lane_of(w_step, j) +: 8] = w_sbox_out[j];
  end

  for (genvar j = 0; j < SBOX_COUNT; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in  (w_sbox_in[j]),
      .inv (w_inv),
      .out (w_sbox_out[j])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_enc   <= 1'b0;
      r_lanes <= '0;
      r_acc   <= '0;
      r_ready <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_ready <= 1'b0;
      if (HOLD_RESULT == 0) r_rd <= '0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_step  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (valid) begin
              r_enc   <= enc;
              r_lanes <= lane_word(rs1, rs2);
              if (!sub) begin
                r_ready <= 1'b1;
                r_rd    <= w_mix;
              end else if (STEPS == 1) begin
                r_ready <= 1'b1;
                r_rd    <= w_sub_next;
              end else begin
                r_acc   <= w_sub_next;
                r_step  <= 2'd1;
                r_state <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            r_acc <= w_sub_next;
            if (r_step == LAST_STEP) begin
              r_ready <= 1'b1;
              r_rd    <= w_sub_next;
              r_step  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_step <= r_step + 2'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ready = r_ready;
  assign rd    = r_rd;

endmodule

// File: tb/tb_aes_v2_scalable.sv
// Randomised bench for aes_v2_scalable: four configurations side by side,
// checked against an arithmetic model of S-box and MixColumn.
module tb_aes_v2_scalable;

  localparam int SC_TAB   [4] = '{1, 2, 4, 2};
  localparam int HOLD_TAB [4] = '{1, 1, 1, 0};

  logic        g_clk;
  logic        g_resetn;
  logic        sub;
  logic        enc;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        valid_v [4];
  logic        ready_v [4];
  logic [31:0] rd_v    [4];

  int          n_vec;
  int          n_bad;
  int          ready_cnt [4];
  logic [31:0] last_rd   [4];
  int          sbox_tab  [256];
  int          isbox_tab [256];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_v2_scalable #(
      .SBOX_COUNT  (SC_TAB[g]),
      .HOLD_RESULT (HOLD_TAB[g])
    ) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .valid    (valid_v[g]),
      .sub      (sub),
      .enc      (enc),
      .flush    (flush),
      .rs1      (rs1),
      .rs2      (rs2),
      .ready    (ready_v[g]),
      .rd       (rd_v[g])
    );
  end

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(negedge g_clk)
    for (int k = 0; k < 4; k++) if (ready_v[k] === 1'b1) ready_cnt[k]++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic int rotl8(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 'hFF;
  endfunction

  task automatic build_tables();
    int v;
    int s;
    for (int x = 0; x < 256; x++) begin
      v = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) v = y;
      s = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 'h63;
      sbox_tab[x]  = s;
      isbox_tab[s] = x;
    end
  endtask

  function automatic logic [31:0] model_sub(input bit e, input logic [31:0] a,
                                            input logic [31:0] b);
    int lane [4];
    logic [31:0] r;
    lane[0] = int'(a[7:0]);
    lane[1] = int'(b[15:8]);
    lane[2] = int'(a[23:16]);
    lane[3] = int'(b[31:24]);
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = 8'(e ? sbox_tab[lane[i]] : isbox_tab[lane[i]]);
    return r;
  endfunction

  function automatic logic [31:0] model_mix(input bit e, input logic [31:0] a,
                                            input logic [31:0] b);
    int col [4];
    int cf  [4];
    int o;
    logic [31:0] r;
    col[0] = int'(a[7:0]);
    col[1] = int'(a[15:8]);
    col[2] = int'(b[23:16]);
    col[3] = int'(b[31:24]);
    if (e) cf = '{2, 3, 1, 1};
    else   cf = '{14, 11, 13, 9};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      o = 0;
      for (int k = 0; k < 4; k++) o = o ^ gmul(cf[k], col[(i + k) % 4]);
      r[8*i +: 8] = 8'(o);
    end
    return r;
  endfunction

  function automatic logic [31:0] idle_rd(input int k);
    return (HOLD_TAB[k] != 0) ? last_rd[k] : 32'h0;
  endfunction

  // Drives one request on instance k and checks latency, result and pulse width.
  task automatic run_op(input int k, input bit s, input bit e,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_rd;
    int lat;
    int n;
    bit seen;
    exp_rd = s ? model_sub(e, a, b) : model_mix(e, a, b);
    lat    = s ? 4 / SC_TAB[k] : 1;
    sub = s; enc = e; rs1 = a; rs2 = b; valid_v[k] = 1'b1;
    @(posedge g_clk); #1;
    valid_v[k] = 1'b0;
    sub = 1'($urandom); enc = 1'($urandom); rs1 = $urandom; rs2 = $urandom;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 8) begin
      if (ready_v[k] === 1'b1) seen = 1'b1;
      else begin
        check($sformatf("busy_rd%0d", k), rd_v[k], idle_rd(k));
        @(posedge g_clk); #1;
        n++;
      end
    end
    check($sformatf("latency%0d", k), 32'(n), 32'(lat));
    check($sformatf("rd%0d", k), rd_v[k], exp_rd);
    last_rd[k] = exp_rd;
    @(posedge g_clk); #1;
    check($sformatf("pulse%0d", k), 32'(ready_v[k]), 32'd0);
    check($sformatf("hold%0d", k), rd_v[k], idle_rd(k));
  endtask

  // Three requests with valid held high; each must start in the previous ready cycle.
  task automatic b2b(input int k);
    bit          q_s   [3];
    bit          q_e   [3];
    logic [31:0] q_a   [3];
    logic [31:0] q_b   [3];
    logic [31:0] q_exp [3];
    int          q_lat [3];
    int got;
    int n;
    int last_n;
    for (int i = 0; i < 3; i++) begin
      q_s[i]   = (i != 1);
      q_e[i]   = 1'($urandom);
      q_a[i]   = $urandom;
      q_b[i]   = $urandom;
      q_exp[i] = q_s[i] ? model_sub(q_e[i], q_a[i], q_b[i]) : model_mix(q_e[i], q_a[i], q_b[i]);
      q_lat[i] = q_s[i] ? 4 / SC_TAB[k] : 1;
    end
    sub = q_s[0]; enc = q_e[0]; rs1 = q_a[0]; rs2 = q_b[0]; valid_v[k] = 1'b1;
    got = 0;
    n = 0;
    last_n = 0;
    while (got < 3 && n < 40) begin
      @(posedge g_clk); #1;
      n++;
      if (ready_v[k] === 1'b1) begin
        check($sformatf("b2b_rd%0d", k), rd_v[k], q_exp[got]);
        check($sformatf("b2b_gap%0d", k), 32'(n - last_n), 32'(q_lat[got]));
        last_rd[k] = q_exp[got];
        last_n = n;
        got++;
        if (got < 3) begin
          sub = q_s[got]; enc = q_e[got]; rs1 = q_a[got]; rs2 = q_b[got];
        end else begin
          valid_v[k] = 1'b0;
        end
      end
    end
    valid_v[k] = 1'b0;
    check($sformatf("b2b_count%0d", k), 32'(got), 32'd3);
    @(posedge g_clk); #1;
    check($sformatf("b2b_tail%0d", k), 32'(ready_v[k]), 32'd0);
  endtask

  initial begin
    int snap;
    n_vec = 0;
    n_bad = 0;
    g_resetn = 1'b0;
    sub = 1'b0; enc = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
    for (int k = 0; k < 4; k++) begin
      valid_v[k] = 1'b0;
      ready_cnt[k] = 0;
      last_rd[k] = '0;
    end
    build_tables();
    repeat (3) @(posedge g_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_ready%0d", k), 32'(ready_v[k]), 32'd0);
      check($sformatf("rst_rd%0d", k), rd_v[k], 32'h0);
    end

    // Release at a falling edge; the first request is accepted on the next rising edge.
    @(negedge g_clk);
    g_resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_op(k, 1'b1, 1'b1, 32'h00530000, 32'hFF000100);
      check($sformatf("vec_sub_enc%0d", k), last_rd[k], 32'h16ED7C63);
      run_op(k, 1'b1, 1'b0, 32'h00ED0063, 32'h16007C00);
      check($sformatf("vec_sub_dec%0d", k), last_rd[k], 32'hFF530100);
      run_op(k, 1'b0, 1'b1, 32'h000013DB, 32'h45530000);
      check($sformatf("vec_mix_enc%0d", k), last_rd[k], 32'hBCA14D8E);
      run_op(k, 1'b0, 1'b0, 32'h00004D8E, 32'hBCA10000);
      check($sformatf("vec_mix_dec%0d", k), last_rd[k], 32'h455313DB);
    end

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom, $urandom);

    // Flush in the second BUSY cycle of a single-S-box SubBytes.
    snap = ready_cnt[0];
    sub = 1'b1; enc = 1'b1; rs1 = $urandom; rs2 = $urandom; valid_v[0] = 1'b1;
    @(posedge g_clk); #1;
    valid_v[0] = 1'b0;
    @(posedge g_clk); #1;
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge g_clk);
    #1;
    check("flush_noready", 32'(ready_cnt[0] - snap), 32'd0);
    check("flush_rd", rd_v[0], last_rd[0]);
    run_op(0, 1'b1, 1'($urandom), $urandom, $urandom);

    // Flush in the same cycle as valid blocks acceptance.
    snap = ready_cnt[2];
    sub = 1'b0; enc = 1'b1; rs1 = $urandom; rs2 = $urandom;
    valid_v[2] = 1'b1; flush = 1'b1;
    @(posedge g_clk); #1;
    valid_v[2] = 1'b0; flush = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    check("flush_block", 32'(ready_cnt[2] - snap), 32'd0);

    b2b(2);
    b2b(1);
    b2b(0);

    // Reset pulse in the middle of a SubBytes on the single-S-box instance.
    sub = 1'b1; enc = 1'b0; rs1 = $urandom; rs2 = $urandom; valid_v[0] = 1'b1;
    @(posedge g_clk); #1;
    valid_v[0] = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midrst_ready%0d", k), 32'(ready_v[k]), 32'd0);
      check($sformatf("midrst_rd%0d", k), rd_v[k], 32'h0);
      last_rd[k] = '0;
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    snap = ready_cnt[0];
    run_op(1, 1'b1, 1'($urandom), $urandom, $urandom);
    repeat (4) @(posedge g_clk);
    #1;
    check("midrst_noready", 32'(ready_cnt[0] - snap), 32'd0);
    run_op(0, 1'b1, 1'($urandom), $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
